// File: rtl/noc_vc_merge_arb_pkg.sv
// Shared NoC types and defaults for the VC merge arbiter
// and the arbiter it reuses.
package noc_vc_merge_arb_pkg;

  localparam int Noc_Flit_Width = 64;
  localparam int Noc_VC_Channel = 4;
  localparam int Noc_VC_Fifo_Depth = 8;

  typedef enum logic {
    ARB_RR = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [Noc_Flit_Width-1:0] flit;
    logic last;
    logic [$clog2(Noc_VC_Channel)-1:0] vc_id;
  } merge_entry_t;

endpackage

// File: rtl/noc_vc_merge_arb_if.sv
// VC-side and port-side flit handshake bundle
// for the merge arbiter.
interface noc_vc_merge_arb_if
  import noc_vc_merge_arb_pkg::*;
#(
  parameter int CHANNELS = Noc_VC_Channel,
  parameter int FLIT_WIDTH = Noc_Flit_Width,
  parameter int FIFO_DEPTH = Noc_VC_Fifo_Depth,
  parameter int VCW = $clog2(CHANNELS)
);

  logic [CHANNELS-1:0] i_valid;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_flit;
  logic [CHANNELS-1:0] i_last;
  logic [CHANNELS-1:0] o_ready;
  logic [CHANNELS-1:0] o_vc_ready;
  logic o_valid;
  logic [FLIT_WIDTH-1:0] o_flit;
  logic o_last;
  logic [VCW-1:0] o_vc_id;
  logic i_ready;
  logic [CHANNELS-1:0] o_grant;
  logic [$clog2(FIFO_DEPTH):0] o_count;

  modport master (
    output i_valid, i_flit, i_last, i_ready,
    input o_ready, o_vc_ready, o_valid, o_flit,
    input o_last, o_vc_id, o_grant, o_count
  );

  modport slave (
    input i_valid, i_flit, i_last, i_ready,
    output o_ready, o_vc_ready, o_valid, o_flit,
    output o_last, o_vc_id, o_grant, o_count
  );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from a
// pointer, or fixed priority with lowest index winning.
module noc_rr_arbiter
  import noc_vc_merge_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  arb_mode_e     mode,
  output logic [N-1:0]  grant
);

  always_comb begin
    logic found;
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = (mode == ARB_FIXED) ? PW'(k) : sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_vc_merge_arb.sv
// Merges per-VC flit streams into one output port through
// a built-in arbiter, wormhole lock and FWFT merge FIFO.
module noc_vc_merge_arb
  import noc_vc_merge_arb_pkg::*;
#(
  parameter int CHANNELS = Noc_VC_Channel,
  parameter int FLIT_WIDTH = Noc_Flit_Width,
  parameter int FIFO_DEPTH = Noc_VC_Fifo_Depth,
  parameter int THRESHOLD = FIFO_DEPTH - 2,
  parameter int ARB_MODE = 0,
  parameter int PACKET_LOCK = 1,
  parameter int VCW = $clog2(CHANNELS)
) (
  input logic noc_clk,
  input logic noc_rst,
  noc_vc_merge_arb_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam arb_mode_e MODE =
    (ARB_MODE != 0) ? ARB_FIXED : ARB_RR;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] flit;
    logic last;
    logic [VCW-1:0] vc_id;
  } entry_t;

  logic [0:0] state;
  logic [VCW-1:0] lock_vc;
  logic [VCW-1:0] ptr;
  logic [VCW-1:0] gidx;
  logic [CHANNELS-1:0] arb_grant;
  logic [CHANNELS-1:0] grant;
  entry_t mem [FIFO_DEPTH];
  entry_t head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic full;
  logic push;
  logic pop;
  logic tail;
  logic vc_rdy;

  noc_rr_arbiter #(
    .N(CHANNELS),
    .PW(VCW)
  ) u_arb (
    .req(bus.i_valid),
    .ptr(ptr),
    .mode(MODE),
    .grant(arb_grant)
  );

  // A held lock keeps the grant even through input bubbles.
  always_comb begin
    grant = '0;
    if (!noc_rst)
      grant = (state == LOCKED) ?
        (CHANNELS'(1) << lock_vc) : arb_grant;
  end

  always_comb begin
    gidx = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (grant[k]) gidx = VCW'(k);
  end

  assign full = (count == CW'(FIFO_DEPTH));
  assign push = |(bus.i_valid & bus.o_ready);
  assign pop = bus.o_valid & bus.i_ready;
  assign tail = bus.i_last[gidx];
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state <= IDLE;
      lock_vc <= '0;
      ptr <= '0;
    end else if (push) begin
      state <= (PACKET_LOCK != 0 && !tail) ? LOCKED : IDLE;
      lock_vc <= gidx;
      if (PACKET_LOCK == 0 || tail)
        ptr <= (gidx == VCW'(CHANNELS - 1)) ?
          '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      vc_rdy <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      vc_rdy <= (count_nxt < CW'(THRESHOLD));
    end
  end

  always_ff @(posedge noc_clk)
    if (push) mem[wr_ptr] <= {bus.i_flit[gidx], tail, gidx};

  always_comb begin
    head = '0;
    if (bus.o_valid) head = mem[rd_ptr];
  end

  assign bus.o_valid = (count != '0);
  assign bus.o_ready = grant & {CHANNELS{!full}};
  assign bus.o_grant = grant;
  assign bus.o_count = count;
  assign bus.o_vc_ready = {CHANNELS{vc_rdy}};
  assign bus.o_flit = head.flit;
  assign bus.o_last = head.last;
  assign bus.o_vc_id = head.vc_id;

endmodule

// File: tb/tb_noc_vc_merge_arb.sv
// Scoreboard bench for noc_vc_merge_arb: RR, fixed
// priority and unlocked instances driven in sequence.
module tb_noc_vc_merge_arb;
  import noc_vc_merge_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  merge_entry_t q_a[$];
  merge_entry_t q_b[$];
  merge_entry_t q_c[$];

  always #5 clk = ~clk;

  noc_vc_merge_arb_if bus_a ();
  noc_vc_merge_arb_if bus_b ();
  noc_vc_merge_arb_if bus_c ();

  noc_vc_merge_arb #(.ARB_MODE(0), .PACKET_LOCK(1)) dut_a (
    .noc_clk(clk), .noc_rst(rst), .bus(bus_a));
  noc_vc_merge_arb #(.ARB_MODE(1), .PACKET_LOCK(1)) dut_b (
    .noc_clk(clk), .noc_rst(rst), .bus(bus_b));
  noc_vc_merge_arb #(.ARB_MODE(0), .PACKET_LOCK(0)) dut_c (
    .noc_clk(clk), .noc_rst(rst), .bus(bus_c));

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input int vc,
                      input logic [63:0] f, input logic l);
    merge_entry_t e;
    e = '{flit: f, last: l, vc_id: 2'(vc)};
    case (which)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic drain(input int which);
    int n;
    logic [3:0] cnt;
    n = 0;
    while (qsize(which) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 128'(qsize(which)), 128'(0));
    @(negedge clk);
    case (which)
      0: cnt = bus_a.o_count;
      1: cnt = bus_b.o_count;
      default: cnt = bus_c.o_count;
    endcase
    chk("drain_count", 128'(cnt), 128'(0));
    cyc();
  endtask

  always @(negedge clk) begin : mon_a
    merge_entry_t e;
    if (!rst && bus_a.o_valid && bus_a.i_ready) begin
      e = (q_a.size() != 0) ? q_a.pop_front() : '1;
      chk("out_a", 128'({bus_a.o_flit, bus_a.o_last,
                         bus_a.o_vc_id}), 128'(e));
    end
  end

  always @(negedge clk) begin : mon_b
    merge_entry_t e;
    if (!rst && bus_b.o_valid && bus_b.i_ready) begin
      e = (q_b.size() != 0) ? q_b.pop_front() : '1;
      chk("out_b", 128'({bus_b.o_flit, bus_b.o_last,
                         bus_b.o_vc_id}), 128'(e));
    end
  end

  always @(negedge clk) begin : mon_c
    merge_entry_t e;
    if (!rst && bus_c.o_valid && bus_c.i_ready) begin
      e = (q_c.size() != 0) ? q_c.pop_front() : '1;
      chk("out_c", 128'({bus_c.o_flit, bus_c.o_last,
                         bus_c.o_vc_id}), 128'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus_a.i_valid = '0; bus_a.i_flit = '0;
    bus_a.i_last = '0; bus_a.i_ready = 1'b0;
    bus_b.i_valid = '0; bus_b.i_flit = '0;
    bus_b.i_last = '0; bus_b.i_ready = 1'b0;
    bus_c.i_valid = '0; bus_c.i_flit = '0;
    bus_c.i_last = '0; bus_c.i_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 128'(bus_a.o_valid), 128'(0));
    chk("rst_count", 128'(bus_a.o_count), 128'(0));
    chk("rst_grant", 128'(bus_a.o_grant), 128'(0));
    chk("rst_ready", 128'(bus_a.o_ready), 128'(0));
    chk("rst_vc_ready", 128'(bus_a.o_vc_ready), 128'(4'hf));
    chk("rst_flit", 128'({bus_a.o_flit, bus_a.o_last,
                          bus_a.o_vc_id}), 128'(0));
    cyc();
    rst = 1'b0;

    // round-robin rotation with single-flit packets
    bus_a.i_ready = 1'b1;
    bus_a.i_last = 4'hf;
    for (int v = 0; v < 4; v++)
      bus_a.i_flit[v] = 64'(256 + v);
    bus_a.i_valid = 4'hf;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", 128'(bus_a.o_grant), 128'(4'b1 << (k % 4)));
      if (k == 0) chk("rr_lat0", 128'(bus_a.o_valid), 128'(0));
      if (k == 1) chk("rr_lat1", 128'(bus_a.o_valid), 128'(1));
      push(0, k % 4, 64'(256 + k % 4), 1'b1);
      cyc();
    end
    bus_a.i_valid = '0;
    drain(0);

    // wormhole lock across a bubble, VC2 waiting
    bus_a.i_last = 4'b0100;
    bus_a.i_flit[1] = 64'h110;
    bus_a.i_flit[2] = 64'h120;
    bus_a.i_valid = 4'b0110;
    @(negedge clk);
    chk("wh_head", 128'(bus_a.o_grant), 128'(4'b0010));
    push(0, 1, 64'h110, 1'b0);
    cyc();
    bus_a.i_valid = 4'b0100;
    @(negedge clk);
    chk("wh_bubble", 128'(bus_a.o_grant), 128'(4'b0010));
    cyc();
    bus_a.i_valid = 4'b0110;
    bus_a.i_flit[1] = 64'h111;
    @(negedge clk);
    chk("wh_body", 128'(bus_a.o_grant), 128'(4'b0010));
    push(0, 1, 64'h111, 1'b0);
    cyc();
    bus_a.i_flit[1] = 64'h112;
    bus_a.i_last = 4'b0110;
    @(negedge clk);
    chk("wh_tail", 128'(bus_a.o_grant), 128'(4'b0010));
    push(0, 1, 64'h112, 1'b1);
    cyc();
    bus_a.i_valid = 4'b0100;
    @(negedge clk);
    chk("wh_vc2", 128'(bus_a.o_grant), 128'(4'b0100));
    push(0, 2, 64'h120, 1'b1);
    cyc();
    bus_a.i_valid = '0;
    drain(0);

    // fill to full with the output stalled
    bus_a.i_ready = 1'b0;
    bus_a.i_last = 4'b0001;
    bus_a.i_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      bus_a.i_flit[0] = 64'(768 + k);
      @(negedge clk);
      chk("bp_count", 128'(bus_a.o_count), 128'(k));
      chk("bp_vc_ready", 128'(bus_a.o_vc_ready),
          128'((k < 6) ? 4'hf : 4'h0));
      chk("bp_ready", 128'(bus_a.o_ready), 128'(4'b0001));
      push(0, 0, 64'(768 + k), 1'b1);
      cyc();
    end
    bus_a.i_flit[0] = 64'(768 + 8);
    @(negedge clk);
    chk("full_count", 128'(bus_a.o_count), 128'(8));
    chk("full_ready", 128'(bus_a.o_ready), 128'(0));
    chk("full_vc_ready", 128'(bus_a.o_vc_ready), 128'(0));
    cyc();
    bus_a.i_ready = 1'b1;
    @(negedge clk);
    cyc();
    bus_a.i_ready = 1'b0;
    @(negedge clk);
    chk("pop_count", 128'(bus_a.o_count), 128'(7));
    chk("resume_ready", 128'(bus_a.o_ready), 128'(4'b0001));
    push(0, 0, 64'(768 + 8), 1'b1);
    cyc();
    bus_a.i_valid = '0;
    @(negedge clk);
    chk("refill_count", 128'(bus_a.o_count), 128'(8));
    cyc();
    bus_a.i_ready = 1'b1;
    drain(0);

    // fixed priority: VC0 starves VC3
    bus_b.i_ready = 1'b1;
    bus_b.i_last = 4'b1001;
    bus_b.i_flit[3] = 64'h430;
    bus_b.i_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      bus_b.i_flit[0] = 64'(1024 + k);
      @(negedge clk);
      chk("fp_grant", 128'(bus_b.o_grant), 128'(4'b0001));
      push(1, 0, 64'(1024 + k), 1'b1);
      cyc();
    end
    bus_b.i_valid = 4'b1000;
    @(negedge clk);
    chk("fp_vc3", 128'(bus_b.o_grant), 128'(4'b1000));
    push(1, 3, 64'h430, 1'b1);
    cyc();
    bus_b.i_valid = '0;
    drain(1);

    // asynchronous reset after VC2's head flit
    bus_a.i_ready = 1'b0;
    bus_a.i_last = 4'b0000;
    bus_a.i_flit[2] = 64'h520;
    bus_a.i_valid = 4'b0100;
    @(negedge clk);
    chk("mr_head", 128'(bus_a.o_grant), 128'(4'b0100));
    cyc();
    bus_a.i_flit[0] = 64'h500;
    bus_a.i_last = 4'b0001;
    bus_a.i_valid = 4'b0101;
    #2;
    chk("mr_count", 128'(bus_a.o_count), 128'(1));
    chk("mr_lock", 128'(bus_a.o_grant), 128'(4'b0100));
    rst = 1'b1;
    #1;
    chk("mr_valid", 128'(bus_a.o_valid), 128'(0));
    chk("mr_count0", 128'(bus_a.o_count), 128'(0));
    chk("mr_grant0", 128'(bus_a.o_grant), 128'(0));
    chk("mr_vc_ready", 128'(bus_a.o_vc_ready), 128'(4'hf));
    cyc();
    rst = 1'b0;
    bus_a.i_ready = 1'b1;
    @(negedge clk);
    chk("mr_vc0_wins", 128'(bus_a.o_grant), 128'(4'b0001));
    push(0, 0, 64'h500, 1'b1);
    cyc();
    bus_a.i_valid = '0;
    drain(0);

    // no packet lock: flits interleave per cycle
    bus_c.i_ready = 1'b1;
    bus_c.i_last = 4'b0000;
    bus_c.i_flit[0] = 64'h600;
    bus_c.i_flit[1] = 64'h610;
    bus_c.i_valid = 4'b0011;
    @(negedge clk);
    chk("nl_g0", 128'(bus_c.o_grant), 128'(4'b0001));
    push(2, 0, 64'h600, 1'b0);
    cyc();
    bus_c.i_flit[0] = 64'h601;
    bus_c.i_last[0] = 1'b1;
    @(negedge clk);
    chk("nl_g1", 128'(bus_c.o_grant), 128'(4'b0010));
    push(2, 1, 64'h610, 1'b0);
    cyc();
    bus_c.i_flit[1] = 64'h611;
    bus_c.i_last[1] = 1'b1;
    @(negedge clk);
    chk("nl_g2", 128'(bus_c.o_grant), 128'(4'b0001));
    push(2, 0, 64'h601, 1'b1);
    cyc();
    bus_c.i_valid = 4'b0010;
    @(negedge clk);
    chk("nl_g3", 128'(bus_c.o_grant), 128'(4'b0010));
    push(2, 1, 64'h611, 1'b1);
    cyc();
    bus_c.i_valid = '0;
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_vc_merge_arb.md
Name: noc_vc_merge_arb

Overview:
Merges CHANNELS virtual-channel flit streams into one output stream, with the arbitration built in.
- Arbiter is round-robin or fixed-priority, selected by parameter.
- With locking enabled, the grant is held until the packet's tail flit is accepted (wormhole).
- Accepted flits go into a first-word-fall-through FIFO, tagged with their source VC ID.
- Each VC receives an almost-full back-pressure indication.
- Sits between the VC allocator stage and the router output port; replaces external-grant merging.

Parameters:
- CHANNELS, 4, number of input VCs (≥2).
- FLIT_WIDTH, 64, flit payload width in bits.
- FIFO_DEPTH, 8, merge FIFO entries (power of two, ≥4).
- THRESHOLD, FIFO_DEPTH-2, occupancy at or above which o_vc_ready deasserts.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- PACKET_LOCK, 1, 1 = hold grant until tail accepted; 0 = re-arbitrate every flit.
- VCW, $clog2(CHANNELS), derived; VC ID width.

Ports:
- noc_clk  in  1  clock, rising edge.
- noc_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  CHANNELS  per-VC flit valid.
- i_flit  in  CHANNELS×FLIT_WIDTH  per-VC flit.
- i_last  in  CHANNELS  per-VC tail-flit marker.
- o_ready  out  CHANNELS  per-VC accept; one-hot or zero.
- o_vc_ready  out  CHANNELS  per-VC almost-full back-pressure; identical across VCs.
- o_valid  out  1  output flit valid.
- o_flit  out  FLIT_WIDTH  output flit.
- o_last  out  1  output tail marker.
- o_vc_id  out  VCW  source VC of the output flit.
- i_ready  in  1  downstream accept.
- o_grant  out  CHANNELS  current one-hot grant; zero when none.
- o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- **Reset** (async assert, sync-safe deassert):
  - o_valid, o_ready, o_grant, o_flit, o_last, o_vc_id, o_count all 0.
  - o_vc_ready all 1.
  - RR pointer = 0; lock state = IDLE.
- **Handshakes.**
  - Input transfer on VC i when i_valid[i] && o_ready[i].
  - Output transfer when o_valid && i_ready.
  - o_valid must not depend combinationally on i_ready.
- **Accept rule.** o_ready[i] = o_grant[i] && !full. No bypass: a full FIFO refuses a push even on a same-cycle pop.
- **Arbitration (combinational from registered state).**
  - RR: the first requesting VC at or after the pointer, wrapping around.
  - Fixed priority: the lowest requesting index.
- **Lock FSM (PACKET_LOCK=1), states IDLE / LOCKED:**
  - IDLE → LOCKED when a granted, accepted flit has i_last=0. The locked VC is registered.
  - In LOCKED, o_grant = the locked VC only, even if its i_valid is low (bubble).
  - LOCKED → IDLE when the locked VC's flit with i_last=1 is accepted.
  - A single-flit packet (i_last=1 on the first flit) stays in IDLE.
- **PACKET_LOCK=0:** the FSM stays in IDLE and arbitration runs every cycle.
- **RR pointer update:** pointer ← granted index + 1 (mod CHANNELS) on acceptance of a tail flit. With PACKET_LOCK=0, it updates on every accepted flit.
- **FIFO:**
  - Each entry stores {flit, last, vc_id}.
  - Latency: a flit accepted in cycle N is visible on o_* in cycle N+1.
  - When empty: o_flit, o_last, o_vc_id are driven to 0.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Back-pressure:** o_vc_ready[i] = (count < THRESHOLD), registered, all bits equal.
- **No request:** o_grant = 0.
- **Mid-packet reset:** the lock and the FIFO contents are discarded; no partial-packet recovery is attempted.

Decomposition:
- Noc_parameters package additions:
  - Noc_Flit_Width, Noc_VC_Channel, Noc_VC_Fifo_Depth reused as defaults.
  - typedef enum {ARB_RR, ARB_FIXED}.
  - typedef struct packed {flit, last, vc_id} merge_entry_t.
- One sub-module: noc_rr_arbiter.
  - Contents: request vector, pointer, mode, one-hot grant.
  - Purpose: reused by the switch allocator.
- The FIFO stays inline.

Test Plan:
- **Round-robin rotation.** Reset, all 4 VCs continuously valid with single-flit packets, i_ready=1 → grants 0,1,2,3,0; o_vc_id sequence 0,1,2,3; o_valid first high one cycle after the first accept.
- **Wormhole lock.** VC1 sends a 3-flit packet with i_valid low in the middle cycle; VC2 valid throughout → o_grant stays 0010 through the bubble; VC2's first flit appears only after VC1's tail.
- **Full / back-pressure.**
  - Setup: i_ready=0, FIFO_DEPTH=8, THRESHOLD=6.
  - After 6 accepts, o_vc_ready drops to 0.
  - After 8 accepts, o_ready=0 and o_count=8.
  - One cycle of i_ready=1 → o_count=7, then accepts resume.
- **Fixed priority.** ARB_MODE=1, VC3 and VC0 valid → VC0 served first; VC3 starves while VC0 stays valid.
- **Reset mid-packet.** Assert noc_rst after VC2's head flit → o_valid=0, o_count=0, o_grant=0, o_vc_ready=1111 immediately (asynchronous); after release, VC0 can win arbitration.
- **PACKET_LOCK=0.** Multi-flit packets on VC0 and VC1 → flits interleave per cycle 0,1,0,1 with the correct o_vc_id tags.
